// File: rtl/codificador_bcd_binario_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   estado_t       : converter FSM states (IDLE, DESPLAZA, FIN)
//   ANCHO_DIGITO   : width of one BCD digit field
//   UMBRAL_AJUSTE  : a shifted digit at or above this value needs correction
//   VALOR_AJUSTE   : amount subtracted from a digit that needs correction
//   DIGITO_MAX     : largest legal BCD digit
package codificador_bcd_binario_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DESPLAZA = 2'd1,
    FIN      = 2'd2
  } estado_t;

  localparam int ANCHO_DIGITO = 4;

  localparam logic [ANCHO_DIGITO-1:0] UMBRAL_AJUSTE = 4'd8;
  localparam logic [ANCHO_DIGITO-1:0] VALOR_AJUSTE  = 4'd3;
  localparam logic [ANCHO_DIGITO-1:0] DIGITO_MAX    = 4'd9;

endpackage

// File: rtl/codificador_bcd_binario_ajuste.sv
// ajuste_digito_bcd: combinational single-digit corrector for reverse
// double-dabble. After the right shift, a digit field of 8 or more has
// received a bit worth 5 in decimal but 8 in binary, so 3 is removed.
// Arithmetic is 4-bit, modulo 16.
//   digito   : shifted 4-bit digit field
//   ajustado : corrected digit field
module ajuste_digito_bcd
  import codificador_bcd_binario_pkg::*;
(
  input  logic [ANCHO_DIGITO-1:0] digito,
  output logic [ANCHO_DIGITO-1:0] ajustado
);

  assign ajustado = (digito >= UMBRAL_AJUSTE) ? (digito - VALOR_AJUSTE) : digito;

endmodule

// File: rtl/codificador_bcd_binario.sv
// codificador_bcd_binario: sequential BCD-to-binary converter using
// reverse double-dabble, one shift/correct iteration per clock.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   inicio    : start request, sampled only in IDLE
//   bcd_in    : packed BCD digits, most significant digit first
//   binario   : last converted value, updated only on a valid done
//   listo     : one-cycle done pulse (high during the FIN cycle)
//   error_bcd : qualifies listo; 1 when any input digit was above 9
//   ocupado   : high whenever the FSM is not in IDLE
//
// Handshake: a request is taken when inicio=1 at a rising edge in IDLE.
// While ocupado=1 (FIN included) inicio is ignored and not queued. The
// result is reported by exactly one cycle of listo with error_bcd valid.
module codificador_bcd_binario
  import codificador_bcd_binario_pkg::*;
#(
  parameter int N_DIGITOS = 3,
  parameter int ANCHO_BIN = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              inicio,
  input  logic [ANCHO_DIGITO*N_DIGITOS-1:0] bcd_in,
  output logic [ANCHO_BIN-1:0]              binario,
  output logic                              listo,
  output logic                              error_bcd,
  output logic                              ocupado
);

  localparam int ANCHO_BCD = ANCHO_DIGITO * N_DIGITOS;
  localparam int ANCHO_SR  = ANCHO_BCD + ANCHO_BIN;
  localparam int ANCHO_CNT = $clog2(ANCHO_BIN + 1);
  localparam logic [ANCHO_CNT-1:0] ULTIMA_ITER = ANCHO_CNT'(ANCHO_BIN - 1);

  estado_t              estado;
  logic [ANCHO_CNT-1:0] contador;
  logic [ANCHO_SR-1:0]  sr;
  logic [ANCHO_SR-1:0]  sr_desp;
  logic [ANCHO_SR-1:0]  sr_next;
  logic                 bcd_invalido;

  // Shift first, then correct every digit field of the shifted value.
  assign sr_desp = sr >> 1;
  assign sr_next[ANCHO_BIN-1:0] = sr_desp[ANCHO_BIN-1:0];

  for (genvar g = 0; g < N_DIGITOS; g++) begin : g_ajuste
    ajuste_digito_bcd u_ajuste (
      .digito   (sr_desp[ANCHO_BIN + g*ANCHO_DIGITO +: ANCHO_DIGITO]),
      .ajustado (sr_next[ANCHO_BIN + g*ANCHO_DIGITO +: ANCHO_DIGITO])
    );
  end

  always_comb begin
    bcd_invalido = 1'b0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (bcd_in[i*ANCHO_DIGITO +: ANCHO_DIGITO] > DIGITO_MAX) begin
        bcd_invalido = 1'b1;
      end
    end
  end

  assign ocupado = (estado != IDLE);

  // listo/error_bcd/binario are set on the edge that enters FIN, so they
  // are high exactly during the FIN cycle and drop on the way back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= IDLE;
      contador  <= '0;
      sr        <= '0;
      binario   <= '0;
      listo     <= 1'b0;
      error_bcd <= 1'b0;
    end else begin
      listo     <= 1'b0;
      error_bcd <= 1'b0;
      case (estado)
        IDLE: begin
          if (inicio) begin
            if (bcd_invalido) begin
              // Bad digit: skip the shifting, report the error, keep binario.
              estado    <= FIN;
              listo     <= 1'b1;
              error_bcd <= 1'b1;
            end else begin
              sr       <= {bcd_in, {ANCHO_BIN{1'b0}}};
              contador <= '0;
              estado   <= DESPLAZA;
            end
          end
        end
        DESPLAZA: begin
          sr       <= sr_next;
          contador <= contador + 1'b1;
          if (contador == ULTIMA_ITER) begin
            estado  <= FIN;
            listo   <= 1'b1;
            binario <= sr_next[ANCHO_BIN-1:0];
          end
        end
        FIN: begin
          estado <= IDLE;
        end
        default: begin
          estado <= IDLE;
        end
      endcase
    end
  end

  // A legal BCD operand is fully drained into the binary part after
  // ANCHO_BIN iterations; anything left over means the datapath is broken.
  always @(posedge clk) begin
    if (!rst && estado == FIN && listo && !error_bcd) begin
      assert (sr[ANCHO_SR-1:ANCHO_BIN] == '0);
    end
  end

endmodule

// File: tb/tb_codificador_bcd_binario.sv
module tb_codificador_bcd_binario;

  logic        clk;
  logic        rst;
  logic        inicio;
  logic [11:0] bcd_in;
  logic [9:0]  binario;
  logic        listo;
  logic        error_bcd;
  logic        ocupado;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] ultimo = '0;   // model of the value binario must hold

  codificador_bcd_binario #(.N_DIGITOS(3), .ANCHO_BIN(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .inicio    (inicio),
    .bcd_in    (bcd_in),
    .binario   (binario),
    .listo     (listo),
    .error_bcd (error_bcd),
    .ocupado   (ocupado)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Decimal value of three packed BCD digits, plus the invalid-digit flag.
  task automatic modelo(input logic [11:0] b, output logic [9:0] v, output bit e);
    int d [3];
    e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d[i] = int'(b[4*i +: 4]);
      if (d[i] > 9) e = 1'b1;
    end
    v = 10'(d[2] * 100 + d[1] * 10 + d[0]);
  endtask

  // Binary-to-BCD decoder used for the round trip.
  function automatic logic [11:0] a_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // ---------------- driver ----------------
  task automatic convertir(input logic [11:0] bcd, input string tag);
    logic [9:0] exp_b;
    bit exp_e;
    int exp_lat, n, n_ocup;
    bit temprano;
    modelo(bcd, exp_b, exp_e);
    if (exp_e) exp_b = ultimo;
    else ultimo = exp_b;
    exp_lat = exp_e ? 1 : 11;
    @(posedge clk); #1;
    bcd_in = bcd;
    inicio = 1'b1;
    @(posedge clk); #1;            // this edge was E0
    inicio = 1'b0;
    bcd_in = 12'($urandom);        // input may change freely after E0
    n = 0; n_ocup = 0; temprano = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (ocupado) n_ocup++;
      if (listo) break;
      if (error_bcd) temprano = 1'b1;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " binario"}, binario, exp_b);
    check({tag, " error_bcd"}, error_bcd, exp_e);
    check({tag, " ocupado_cycles"}, n_ocup, exp_lat);
    check({tag, " error_outside_fin"}, temprano, 0);
    @(negedge clk);
    check({tag, " after_fin listo/err/ocupado"}, {listo, error_bcd, ocupado}, 3'b000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit got, vio;
    int t;
    int tiempos [$];
    logic [3:0] d [3];

    rst = 1'b1; inicio = 1'b0; bcd_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {binario, listo, error_bcd, ocupado}, 13'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed values
    convertir(12'h000, "bcd_000");
    convertir(12'h999, "bcd_999");
    convertir(12'h128, "bcd_128");
    convertir(12'h255, "bcd_255");
    convertir(12'h1A3, "bcd_1A3_invalid");   // must keep 255
    convertir(12'hF00, "bcd_F00_invalid");
    convertir(12'h00C, "bcd_00C_invalid");

    // Round trip through the binary-to-BCD decoder
    for (int v = 0; v < 256; v++) begin
      convertir(a_bcd(v), $sformatf("round_trip_%0d", v));
    end

    // Random digits, roughly one in eight out of range
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 3; i++) begin
        d[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      convertir({d[2], d[1], d[0]}, $sformatf("random_%0d", k));
    end

    // inicio during a conversion is ignored
    @(posedge clk); #1;
    bcd_in = 12'h500; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    n = 0; got = 1'b0;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (listo) got = 1'b1;
      if (n == 2) begin inicio = 1'b1; bcd_in = 12'h777; end
      if (n == 3) inicio = 1'b0;
    end
    ultimo = 10'd500;
    check("ignored_start latency", n, 11);
    check("ignored_start binario", binario, 500);
    check("ignored_start error_bcd", error_bcd, 0);
    vio = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ocupado || listo) vio = 1'b1;
    end
    check("ignored_start not queued", vio, 0);

    // Reset mid-conversion aborts; rst wins over a simultaneous inicio
    @(posedge clk); #1;
    bcd_in = 12'h123; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    n = 0; got = 1'b0;
    while (n < 5) begin
      @(negedge clk);
      n++;
      if (listo) got = 1'b1;
    end
    rst = 1'b1; inicio = 1'b1;
    @(negedge clk);
    rst = 1'b0; inicio = 1'b0;
    ultimo = '0;
    check("abort binario", binario, 0);
    check("abort ocupado", ocupado, 0);
    check("abort listo", listo, 0);
    repeat (15) begin
      @(negedge clk);
      if (listo || ocupado) got = 1'b1;
    end
    check("abort no listo", got, 0);

    // inicio held high: back-to-back conversions every 12 cycles
    @(posedge clk); #1;
    bcd_in = 12'h042; inicio = 1'b1;
    t = 0; vio = 1'b0;
    while (t < 80 && tiempos.size() < 3) begin
      @(negedge clk);
      t++;
      if (listo) begin
        tiempos.push_back(t);
        if (binario !== 10'd42 || error_bcd !== 1'b0) vio = 1'b1;
      end
    end
    inicio = 1'b0;
    check("held pulses", tiempos.size(), 3);
    check("held values", vio, 0);
    if (tiempos.size() == 3) begin
      check("held gap 1", tiempos[1] - tiempos[0], 12);
      check("held gap 2", tiempos[2] - tiempos[1], 12);
    end
    n = 0;
    while (n < 20 && ocupado) begin
      @(negedge clk);
      n++;
    end
    check("held drains to idle", ocupado, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/codificador_bcd_binario.md
Name: codificador_bcd_binario

Overview:
- Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from any digit that is ≥8.
- It is the inverse of the display-side binary-to-BCD decoder. It takes operands typed as decimal digits (centenas/decenas/unidades) and feeds the Booth multiplier datapath in binary.
- One iteration per clock, with a start/done handshake and invalid-digit detection.

Parameters:
- N_DIGITOS, 3, number of BCD input digits; packed as 4*N_DIGITOS bits, most significant digit first.
- ANCHO_BIN, 10, binary output width and iteration count. Must satisfy 2^ANCHO_BIN ≥ 10^N_DIGITOS.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- inicio  input  1  start request; sampled only in IDLE.
- bcd_in  input  4*N_DIGITOS  packed digits {centenas, decenas, unidades} for the default configuration.
- binario  output  ANCHO_BIN  converted value; holds the last result until the next done.
- listo  output  1  one-cycle done pulse.
- error_bcd  output  1  valid only with listo; 1 when any input digit was >9.
- ocupado  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=1 at an edge): state→IDLE, iteration counter→0, shift register→0, binario→0, listo→0, error_bcd→0, ocupado→0.
- Reset mid-conversion aborts it: no listo pulse is produced, and binario returns to 0.
- States:
  - IDLE: ocupado=0. If inicio=1 at edge E0, latch bcd_in and check every digit.
    - All digits ≤9: load shift register {bcd_in, ANCHO_BIN'b0}, counter=0, go to DESPLAZA.
    - Any digit >9: go to FIN with err flag set. The shift register is not loaded.
  - DESPLAZA: each cycle, shift the whole register (4*N_DIGITOS+ANCHO_BIN bits) right by 1. Then, for each 4-bit digit field of the shifted value, subtract 3 if the field is ≥8 (combinational, same cycle). Increment the counter; after the ANCHO_BIN-th iteration go to FIN.
  - FIN: one cycle, then IDLE.
    - Valid input: binario ← low ANCHO_BIN bits of the register, error_bcd=0.
    - Invalid input: binario unchanged, error_bcd=1.
    - listo=1 in this cycle.
- Latency:
  - Valid input: listo visible after edge E0+ANCHO_BIN+1 (11 cycles for the default).
  - Invalid input: listo visible after edge E0+1.
- Handshake:
  - inicio is ignored while ocupado=1, including during the FIN cycle; no queuing.
  - bcd_in may change freely after E0.
  - Back-to-back conversion: inicio held high is accepted on the first IDLE cycle after FIN.
- Arithmetic rules:
  - Digit correction is 4-bit, modulo 16.
  - For valid inputs the upper BCD field is guaranteed zero at FIN. An implementation assertion checks this.
  - The result is unsigned. Maximum value is 10^N_DIGITOS−1 (999 for the default).
- Boundaries:
  - Input 000 converts normally (full latency) and yields 0.
  - Digit values 10–15 in any position are flagged.
  - listo and error_bcd are never high outside FIN.
  - When rst and inicio are both high, rst wins.

Decomposition:
- Shared package contents:
  - state encoding: IDLE, DESPLAZA, FIN
  - UMBRAL_AJUSTE=8 and VALOR_AJUSTE=3
  - DIGITO_MAX=9
  - digit width constant ANCHO_DIGITO=4
- One natural sub-module: ajuste_digito_bcd, a combinational 4-bit "if ≥8 then −3" corrector, instantiated N_DIGITOS times via generate.
- The FSM, counter and shift register live in the top module.

Test Plan:
- rst, then bcd_in={0,0,0}, inicio for 1 cycle → listo after 11 cycles, binario=0, error_bcd=0, ocupado high for 11 cycles.
- bcd_in={9,9,9} → binario=999 (0x3E7), error_bcd=0; bcd_in={2,5,5} → binario=255; {1,2,8} → 128.
- Round trip: sweep 0–255 through the team's binary-to-BCD decoder into this block → binario equals the original value for all 256 values.
- bcd_in={1,0xA,3} → listo after 1 cycle with error_bcd=1, binario keeps the previous result (255).
- Start {5,0,0}; at cycle 3 pulse inicio with {7,7,7} → ignored, result 500. At cycle 5 of a second conversion assert rst → no listo, binario=0, ocupado=0 next cycle.
- inicio held high continuously with {0,4,2} → listo every 12 cycles, each with binario=42.
